// File: rtl/stack_pkg.sv
// Shared types for the stack router merge path: flit layout and the
// arbiter / per-input state encodings.
package stack_pkg;
  localparam int FLIT_W_DEF = 11;
  localparam int TAIL_BIT   = FLIT_W_DEF - 1;

  typedef logic [FLIT_W_DEF-1:0] flit_t;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCK = 1'b1} arb_state_e;
  typedef enum logic {IN_SYNC = 1'b0, IN_LIVE = 1'b1} in_state_e;
endpackage

// File: rtl/flit_fifo.sv
// Per-input flit buffer: show-ahead head word, registered full/empty derived
// from an occupancy count one bit wider than the pointers.
module flit_fifo #(
  parameter int FLIT_W = 11,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [FLIT_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_next;
  logic              do_wr, do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_wr && !do_rd)      count_next = count + CW'(1);
    else if (do_rd && !do_wr) count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end
endmodule

// File: rtl/stack_packet_merge.sv
// Packet-atomic round-robin merge of NUM_IN flit streams onto one output,
// with optional per-input resync that drops partial packets after reset.
module stack_packet_merge
  import stack_pkg::*;
#(
  parameter int NUM_IN     = 2,
  parameter int FLIT_W     = FLIT_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int RESYNC     = 1,
  localparam int GW        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN*FLIT_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [GW-1:0]            out_grant,
  output logic [NUM_IN-1:0]        in_synced,
  output logic [15:0]              pkt_cnt
);
  typedef struct packed {
    arb_state_e  state;
    logic [GW-1:0] idx;
    logic [GW-1:0] rr_ptr;
  } arb_t;

  arb_t              arb_q, arb_d;
  logic [FLIT_W-1:0] head [NUM_IN];
  logic [NUM_IN-1:0] fifo_full, fifo_empty, fifo_wr, live, avail, pop;
  logic [NUM_IN-1:0] avail_rot;
  logic              pick_found;
  logic [GW:0]       pick_sum;
  logic [GW-1:0]     pick, sel;
  logic              have_src, load, out_free, sel_tail;
  logic [FLIT_W-1:0] head_sel;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
    return (v == GW'(NUM_IN - 1)) ? '0 : v + GW'(1);
  endfunction

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    logic [FLIT_W-1:0] flit;
    in_state_e         st;

    assign flit = in_data[i*FLIT_W +: FLIT_W];

    // In SYNC every offered flit is swallowed; a tail marks a packet boundary.
    always_ff @(posedge clk) begin
      if (reset) begin
        if (RESYNC != 0) st <= IN_SYNC;
        else             st <= IN_LIVE;
      end else if (st == IN_SYNC && in_valid[i] && flit[FLIT_W-1]) begin
        st <= IN_LIVE;
      end
    end

    assign live[i]     = (st == IN_LIVE);
    assign in_ready[i] = live[i] ? !fifo_full[i] : 1'b1;
    assign fifo_wr[i]  = live[i] && in_valid[i] && !fifo_full[i];

    flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (fifo_wr[i]),
      .wr_data (flit),
      .rd_en   (pop[i]),
      .rd_data (head[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );
  end

  assign in_synced = live;
  assign avail     = live & ~fifo_empty;

  // Rotate so bit 0 is rr_ptr; the first set bit is the round-robin winner.
  always_comb begin
    avail_rot  = NUM_IN'({avail, avail} >> arb_q.rr_ptr);
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!pick_found && avail_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, arb_q.rr_ptr} + (GW+1)'(k);
      end
    end
    if (pick_sum >= (GW+1)'(NUM_IN)) pick = GW'(pick_sum - (GW+1)'(NUM_IN));
    else                             pick = GW'(pick_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) arb_q <= '{state: ARB_IDLE, idx: '0, rr_ptr: '0};
    else       arb_q <= arb_d;
  end

  always_comb begin
    arb_d = arb_q;
    case (arb_q.state)
      ARB_IDLE: begin
        if (pick_found) begin
          if (load && sel_tail) begin
            arb_d.rr_ptr = wrap_inc(pick);
          end else begin
            arb_d.state = ARB_LOCK;
            arb_d.idx   = pick;
          end
        end
      end
      ARB_LOCK: begin
        if (load && sel_tail) begin
          arb_d.state  = ARB_IDLE;
          arb_d.rr_ptr = wrap_inc(arb_q.idx);
        end
      end
      default: arb_d = arb_q;
    endcase
  end

  // While locked only the owner may feed the output, even if it runs dry.
  always_comb begin
    out_free = !out_valid || out_ready;
    if (arb_q.state == ARB_LOCK) begin
      sel      = arb_q.idx;
      have_src = avail[arb_q.idx];
    end else begin
      sel      = pick;
      have_src = pick_found;
    end
    load     = out_free && have_src;
    head_sel = head[sel];
    sel_tail = head_sel[FLIT_W-1];
    pop      = load ? (NUM_IN'(1) << sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      pkt_cnt   <= '0;
    end else begin
      if (out_free) out_valid <= have_src;
      if (load) begin
        out_data  <= head_sel;
        out_grant <= sel;
      end
      if (out_valid && out_ready && out_data[FLIT_W-1]) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
endmodule
